// File: rtl/uart_test_pkg.sv
// Shared constants for the UART echo tester: FSM state codes, LFSR taps and defaults.
package uart_test_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_SEND    = 3'd1;
  localparam logic [2:0] ST_WAIT_RX = 3'd2;
  localparam logic [2:0] ST_NEXT    = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  localparam logic [7:0]  LFSR_TAPS   = 8'hB8;
  localparam logic [31:0] DEF_TIMEOUT = 32'd50000;
  localparam logic [7:0]  DEF_SEED    = 8'h5A;

  // Fibonacci step for x^8+x^6+x^5+x^4+1, shifting toward the MSB.
  function automatic logic [7:0] lfsr8_next(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/pattern_gen.sv
// Test byte source for the echo tester. Define UART_ECHO_TESTER_LFSR_EN for an
// 8-bit LFSR pattern (top N bits used); otherwise an incrementing counter from SEED.
module pattern_gen
  import uart_test_pkg::*;
#(
  parameter int unsigned N    = 8,
  parameter logic [7:0]  SEED = DEF_SEED
) (
  input  logic         sysclk,
  input  logic         reset,
  input  logic         load,
  input  logic         advance,
  output logic [N-1:0] value
);

`ifdef UART_ECHO_TESTER_LFSR_EN
  logic [7:0] lfsr;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      lfsr <= '0;
    end else if (load) begin
      lfsr <= SEED;
    end else if (advance) begin
      lfsr <= lfsr8_next(lfsr);
    end
  end

  assign value = lfsr[7 -: N];
`else
  logic [N-1:0] cnt;

  always_ff @(posedge sysclk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= N'(SEED);
    end else if (advance) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign value = cnt;
`endif

endmodule

// File: rtl/uart_echo_tester.sv
// Burst echo tester for my_uart: sends a byte pattern, checks each echo within TIMEOUT.
// Pattern source selected by UART_ECHO_TESTER_LFSR_EN (see pattern_gen).
module uart_echo_tester
  import uart_test_pkg::*;
#(
  parameter int unsigned N         = 8,
  parameter int unsigned NUM_BYTES = 16,
  parameter logic [31:0] TIMEOUT   = DEF_TIMEOUT,
  parameter logic [7:0]  SEED      = DEF_SEED,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             start_i,
  output logic             tx_start_o,
  output logic [N-1:0]     tx_data_o,
  input  logic             tx_end_i,
  input  logic             rx_end_i,
  input  logic             rx_err_i,
  input  logic [N-1:0]     rx_data_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] err_cnt_o
);

  localparam int unsigned         IDX_W    = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(NUM_BYTES - 1);
  localparam logic [31:0]         TMO_LAST = TIMEOUT - 32'd1;

  logic [2:0]       state, state_nx;
  logic [IDX_W-1:0] idx;
  logic [31:0]      timer;
  logic [CNT_W-1:0] err_cnt;
  logic             tx_done;
  logic             pass_q;
  logic             pat_load, pat_adv;
  logic [N-1:0]     pattern;
  logic             timeout_hit;
  logic             byte_bad;
  logic             last_byte;

  pattern_gen #(
    .N    (N),
    .SEED (SEED)
  ) u_pattern_gen (
    .sysclk  (sysclk),
    .reset   (reset),
    .load    (pat_load),
    .advance (pat_adv),
    .value   (pattern)
  );

  assign timeout_hit = (timer == TMO_LAST);
  assign last_byte   = (idx == LAST_IDX);
  // A received frame takes priority over a timeout landing in the same cycle.
  assign byte_bad    = rx_end_i ? (rx_err_i || (rx_data_i != pattern)) : timeout_hit;

  always_comb begin
    state_nx = state;
    pat_load = 1'b0;
    pat_adv  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          state_nx = ST_SEND;
          pat_load = 1'b1;
        end
      end
      ST_SEND:    state_nx = ST_WAIT_RX;
      ST_WAIT_RX: if (rx_end_i || timeout_hit) state_nx = ST_NEXT;
      ST_NEXT: begin
        if (tx_done) begin
          if (last_byte) begin
            state_nx = ST_DONE;
          end else begin
            state_nx = ST_SEND;
            pat_adv  = 1'b1;
          end
        end
      end
      ST_DONE:    state_nx = ST_IDLE;
      default:    state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state   <= ST_IDLE;
      idx     <= '0;
      timer   <= '0;
      err_cnt <= '0;
      tx_done <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        ST_IDLE: begin
          if (start_i) begin
            idx     <= '0;
            timer   <= '0;
            err_cnt <= '0;
            pass_q  <= 1'b0;
          end
        end
        ST_WAIT_RX: begin
          timer <= timer + 32'd1;
          if ((rx_end_i || timeout_hit) && byte_bad && (err_cnt != '1)) begin
            err_cnt <= err_cnt + 1'b1;
          end
        end
        ST_NEXT: begin
          // pass_o is updated on the edge into DONE so it lines up with done_o.
          if (tx_done) begin
            if (last_byte) begin
              pass_q <= (err_cnt == '0);
            end else begin
              idx   <= idx + 1'b1;
              timer <= '0;
            end
          end
        end
        default: ;
      endcase

      if (state_nx == ST_SEND) begin
        tx_done <= 1'b0;
      end else if ((state != ST_IDLE) && tx_end_i) begin
        tx_done <= 1'b1;
      end
    end
  end

  assign tx_start_o = (state == ST_SEND);
  assign tx_data_o  = pattern;
  assign busy_o     = (state != ST_IDLE);
  assign done_o     = (state == ST_DONE);
  assign pass_o     = pass_q;
  assign err_cnt_o  = err_cnt;

endmodule
